// File: rtl/regfile_mp.sv
// Two-read / two-write register file with a per-register pending scoreboard.
// Reads are registered and see the writes and reservations accepted at the same edge.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data0,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_busy0,
    output logic              rd_busy1,
    input  logic              wr_en0,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DEPTH-1:0]  busy_vec
);

    logic [DEPTH-1:0][DATA_W-1:0] regs_q;
    logic [DEPTH-1:0][DATA_W-1:0] regs_nxt;
    logic [DEPTH-1:0]             busy_q;
    logic [DEPTH-1:0]             busy_nxt;

    // Post-edge state; port 1 is applied after port 0 so it wins on a shared
    // address, and the reservation is applied last so it wins over a write.
    always_comb begin
        regs_nxt = regs_q;
        busy_nxt = busy_q;
        if (wr_en0) begin
            regs_nxt[wr_addr0] = wr_data0;
            busy_nxt[wr_addr0] = 1'b0;
        end
        if (wr_en1) begin
            regs_nxt[wr_addr1] = wr_data1;
            busy_nxt[wr_addr1] = 1'b0;
        end
        if (rsv_en) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        if (ZERO_R0 != 0) begin
            regs_nxt[0] = '0;
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q   <= '0;
            busy_q   <= '0;
            rd_data0 <= '0;
            rd_data1 <= '0;
            rd_busy0 <= 1'b0;
            rd_busy1 <= 1'b0;
        end else begin
            regs_q   <= regs_nxt;
            busy_q   <= busy_nxt;
            rd_data0 <= regs_nxt[rd_addr0];
            rd_data1 <= regs_nxt[rd_addr1];
            rd_busy0 <= busy_nxt[rd_addr0];
            rd_busy1 <= busy_nxt[rd_addr1];
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and random checks of regfile_mp against a reference model and
// an expected-result queue per read port.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rd_addr0, rd_addr1;
    logic [31:0] rd_data0, rd_data1;
    logic        rd_busy0, rd_busy1;
    logic        wr_en0, wr_en1;
    logic [3:0]  wr_addr0, wr_addr1;
    logic [31:0] wr_data0, wr_data1;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic [15:0] busy_vec;

    regfile_mp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .rd_busy0 (rd_busy0),
        .rd_busy1 (rd_busy1),
        .wr_en0   (wr_en0),
        .wr_en1   (wr_en1),
        .wr_addr0 (wr_addr0),
        .wr_addr1 (wr_addr1),
        .wr_data0 (wr_data0),
        .wr_data1 (wr_data1),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_vec (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [16];
    logic [15:0] m_busy;
    logic [31:0] exp_d0_q [$];
    logic [31:0] exp_d1_q [$];
    logic [17:0] exp_b_q  [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    task automatic idle_inputs();
        wr_en0 = 1'b0; wr_en1 = 1'b0; rsv_en = 1'b0;
        wr_addr0 = '0; wr_addr1 = '0; rsv_addr = '0;
        wr_data0 = '0; wr_data1 = '0;
    endtask

    // Update the model with the driven inputs, queue the expected reads,
    // clock once, then pop and compare.
    task automatic step(input string tag);
        logic [31:0] e0, e1;
        logic [17:0] eb;
        if (wr_en0 && wr_addr0 != 4'd0) begin
            m_regs[wr_addr0] = wr_data0;
            m_busy[wr_addr0] = 1'b0;
        end
        if (wr_en1 && wr_addr1 != 4'd0) begin
            m_regs[wr_addr1] = wr_data1;
            m_busy[wr_addr1] = 1'b0;
        end
        if (rsv_en && rsv_addr != 4'd0) m_busy[rsv_addr] = 1'b1;
        exp_d0_q.push_back(m_regs[rd_addr0]);
        exp_d1_q.push_back(m_regs[rd_addr1]);
        exp_b_q.push_back({m_busy[rd_addr0], m_busy[rd_addr1], m_busy});
        @(posedge clk);
        #1;
        e0 = exp_d0_q.pop_front();
        e1 = exp_d1_q.pop_front();
        eb = exp_b_q.pop_front();
        check({tag, " rd_data0"}, 64'(rd_data0), 64'(e0));
        check({tag, " rd_data1"}, 64'(rd_data1), 64'(e1));
        check({tag, " rd_busy0"}, 64'(rd_busy0), 64'(eb[17]));
        check({tag, " rd_busy1"}, 64'(rd_busy1), 64'(eb[16]));
        check({tag, " busy_vec"}, 64'(busy_vec), 64'(eb[15:0]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rd_data0"}, 64'(rd_data0), 64'd0);
        check({tag, " rd_data1"}, 64'(rd_data1), 64'd0);
        check({tag, " rd_busy0"}, 64'(rd_busy0), 64'd0);
        check({tag, " rd_busy1"}, 64'(rd_busy1), 64'd0);
        check({tag, " busy_vec"}, 64'(busy_vec), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr0 = 4'd3; rd_addr1 = 4'd15;
        idle_inputs();
        model_reset();
        #12;
        check_all_zero("reset_async");
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Reads after reset
        step("post_reset");

        // Write-first bypass on port 0
        wr_en0 = 1'b1; wr_addr0 = 4'd5; wr_data0 = 32'hDEADBEEF; rd_addr0 = 4'd5;
        step("bypass_w0");
        idle_inputs();

        // Both ports write register 7: port 1 wins, in bypass and in storage
        wr_en0 = 1'b1; wr_addr0 = 4'd7; wr_data0 = 32'h1111;
        wr_en1 = 1'b1; wr_addr1 = 4'd7; wr_data1 = 32'h2222;
        rd_addr0 = 4'd7; rd_addr1 = 4'd7;
        step("dual_write_bypass");
        idle_inputs();
        rd_addr1 = 4'd5;
        step("dual_write_stored");

        // Register 0 ignores writes and reservations
        wr_en0 = 1'b1; wr_addr0 = 4'd0; wr_data0 = 32'hFFFFFFFF;
        wr_en1 = 1'b1; wr_addr1 = 4'd0; wr_data1 = 32'h12345678;
        rsv_en = 1'b1; rsv_addr = 4'd0; rd_addr0 = 4'd0; rd_addr1 = 4'd0;
        step("zero_r0");
        idle_inputs();

        // Scoreboard on register 9
        rsv_en = 1'b1; rsv_addr = 4'd9; rd_addr0 = 4'd9; rd_addr1 = 4'd9;
        step("rsv9");
        idle_inputs();
        step("rsv9_hold");
        wr_en1 = 1'b1; wr_addr1 = 4'd9; wr_data1 = 32'h00C0FFEE;
        step("write9_clears");
        idle_inputs();
        rsv_en = 1'b1; rsv_addr = 4'd9;
        wr_en0 = 1'b1; wr_addr0 = 4'd9; wr_data0 = 32'h99;
        step("rsv_and_write9");
        idle_inputs();
        wr_en0 = 1'b1; wr_addr0 = 4'd3; wr_data0 = 32'h33;
        rd_addr1 = 4'd3;
        step("write_not_busy");
        idle_inputs();

        // Reservation plus write on 4, then asynchronous reset between edges
        rsv_en = 1'b1; rsv_addr = 4'd4;
        wr_en0 = 1'b1; wr_addr0 = 4'd4; wr_data0 = 32'hA5; rd_addr0 = 4'd4;
        step("rsv_write4");
        idle_inputs();
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_op");
        model_reset();
        wr_en0 = 1'b1; wr_addr0 = 4'd4; wr_data0 = 32'h5A;
        rsv_en = 1'b1; rsv_addr = 4'd6;
        @(posedge clk); #1;
        check_all_zero("reset_blocks_updates");
        idle_inputs();
        #2;
        rst_n = 1'b1;
        rd_addr0 = 4'd4; rd_addr1 = 4'd6;
        step("after_reset_reads");

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            wr_en0   = 1'($urandom_range(0, 1));
            wr_en1   = 1'($urandom_range(0, 1));
            rsv_en   = 1'($urandom_range(0, 1));
            wr_addr0 = 4'($urandom_range(0, 15));
            wr_addr1 = (n % 4 == 0) ? wr_addr0 : 4'($urandom_range(0, 15));
            rsv_addr = (n % 5 == 0) ? wr_addr1 : 4'($urandom_range(0, 15));
            wr_data0 = $urandom;
            wr_data1 = $urandom;
            rd_addr0 = (n % 3 == 0) ? wr_addr0 : 4'($urandom_range(0, 15));
            rd_addr1 = (n % 3 == 1) ? wr_addr1 : 4'($urandom_range(0, 15));
            step("random");
        end
        idle_inputs();

        check("queues_drained", 64'(exp_d0_q.size() + exp_d1_q.size() + exp_b_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
